seg_7_scan: RTL and testbench

SEG_7_SCAN -- requirements
Module: seg_7_scan

---
 rtl/seg7_pkg.sv | 6 +
 rtl/seg_7_scan.sv | 86 ++++++++
 tb/tb_seg_7_scan.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the multiplexed seven-segment scanner
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, DISPLAY, BLANK} state_t;
  localparam int NUM_DIGITS = 6;
  localparam logic [6:0] SEG_OFF = 7'b111_1111;
endpackage

// File: rtl/seg_7_scan.sv
// seg_7_scan: time-multiplexes six snapshotted digit patterns onto a shared active-low segment bus
module seg_7_scan
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [6:0] seg4,
  input  logic [6:0] seg5,
  input  logic [5:0] dp,
  input  logic       en,
  output logic [5:0] sel,
  output logic [7:0] seg_out,
  output logic       frame_start
);
  localparam int CW = $clog2(DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES);
  localparam logic [CW-1:0] D_LOAD = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] B_LOAD = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  state_t state, state_n;
  logic [2:0] idx, idx_n, idx_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_DIGITS-1:0][6:0] seg_in, snap_seg, seg_sel;
  logic [NUM_DIGITS-1:0] snap_dp, dp_sel;
  logic load;
  assign seg_in = {seg5, seg4, seg3, seg2, seg1, seg0};
  assign idx_inc = idx == 3'(NUM_DIGITS - 1) ? 3'd0 : idx + 3'd1;
  // load marks every entry to digit 0: the only point inputs are sampled
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt - CW'(1);
    load = 1'b0;
    if (!en) begin
      state_n = IDLE;
      idx_n = 3'd0;
      cnt_n = '0;
    end else if (state == IDLE) begin
      state_n = DISPLAY;
      idx_n = 3'd0;
      cnt_n = D_LOAD;
      load = 1'b1;
    end else if (cnt == '0) begin
      if (state == DISPLAY && BLANK_CYCLES > 0) begin
        state_n = BLANK;
        cnt_n = B_LOAD;
      end else begin
        state_n = DISPLAY;
        idx_n = idx_inc;
        cnt_n = D_LOAD;
        load = idx_inc == 3'd0;
      end
    end
  end
  assign seg_sel = load ? seg_in : snap_seg;
  assign dp_sel = load ? dp : snap_dp;
  // sel and seg_out are registered together so a digit never shows its neighbour's data
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      idx <= 3'd0;
      cnt <= '0;
      snap_seg <= {NUM_DIGITS{SEG_OFF}};
      snap_dp <= '0;
      sel <= '1;
      seg_out <= {1'b1, SEG_OFF};
      frame_start <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      if (load) begin
        snap_seg <= seg_in;
        snap_dp <= dp;
      end
      sel <= state_n == DISPLAY ? ~(6'b1 << idx_n) : '1;
      seg_out <= state_n == DISPLAY ? {~dp_sel[idx_n], seg_sel[idx_n]} : {1'b1, SEG_OFF};
      frame_start <= load;
    end
  end
endmodule

// File: tb/tb_seg_7_scan.sv
// tb_seg_7_scan: directed checks of scan order, blanking, snapshotting, enable and async reset
module tb_seg_7_scan;
  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] s0, s1, s2, s3, s4, s5;
  logic [5:0] dp;
  logic en_a, en_b;
  logic [5:0] sel_a, sel_b;
  logic [7:0] so_a, so_b;
  logic fs_a, fs_b, fs_a_q, fs_b_q;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  seg_7_scan #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2)) u_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .seg0(s0), .seg1(s1), .seg2(s2), .seg3(s3),
    .seg4(s4), .seg5(s5), .dp(dp), .en(en_a), .sel(sel_a), .seg_out(so_a), .frame_start(fs_a));
  seg_7_scan #(.DIGIT_CYCLES(4), .BLANK_CYCLES(0)) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .seg0(s0), .seg1(s1), .seg2(s2), .seg3(s3),
    .seg4(s4), .seg5(s5), .dp(dp), .en(en_b), .sel(sel_b), .seg_out(so_b), .frame_start(fs_b));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic to_edge(input int n);
    while (cyc < n) tick();
  endtask
  always @(negedge clk) begin
    chk("onehot_a", 8'($countones(~sel_a) <= 1), 8'd1);
    chk("onehot_b", 8'($countones(~sel_b) <= 1), 8'd1);
    chk("fs_width_a", 8'(fs_a && fs_a_q), 8'd0);
    chk("fs_width_b", 8'(fs_b && fs_b_q), 8'd0);
    fs_a_q = fs_a;
    fs_b_q = fs_b;
  end
  initial begin
    fs_a_q = 1'b0;
    fs_b_q = 1'b0;
    rst_n = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    {s0, s1, s2, s3, s4, s5} = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
    dp = 6'b000001;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_sel", {2'b0, sel_a}, 8'h3F);
    chk("rst_seg", so_a, 8'hFF);
    chk("rst_fs", {7'b0, fs_a}, 8'h00);
    rst_n = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    cyc = 0;
    to_edge(1);
    chk("d0_sel", {2'b0, sel_a}, 8'h3E);
    chk("d0_seg", so_a, 8'h40);
    chk("d0_fs", {7'b0, fs_a}, 8'h01);
    chk("b_d0_sel", {2'b0, sel_b}, 8'h3E);
    chk("b_d0_fs", {7'b0, fs_b}, 8'h01);
    to_edge(2);
    chk("d0_fs_low", {7'b0, fs_a}, 8'h00);
    chk("d0_sel_2", {2'b0, sel_a}, 8'h3E);
    to_edge(4);
    chk("d0_sel_4", {2'b0, sel_a}, 8'h3E);
    to_edge(5);
    chk("blank_sel", {2'b0, sel_a}, 8'h3F);
    chk("blank_seg", so_a, 8'hFF);
    chk("b_d1_sel", {2'b0, sel_b}, 8'h3D);
    chk("b_d1_seg", so_b, 8'hF9);
    to_edge(6);
    chk("blank_sel_2", {2'b0, sel_a}, 8'h3F);
    to_edge(7);
    chk("d1_sel", {2'b0, sel_a}, 8'h3D);
    chk("d1_seg", so_a, 8'hF9);
    to_edge(13);
    chk("d2_sel", {2'b0, sel_a}, 8'h3B);
    chk("d2_seg", so_a, 8'hA4);
    to_edge(19);
    chk("d3_sel", {2'b0, sel_a}, 8'h37);
    chk("d3_seg", so_a, 8'hB0);
    to_edge(20);
    s0 = 7'h00;
    to_edge(25);
    chk("d4_sel", {2'b0, sel_a}, 8'h2F);
    chk("d4_seg", so_a, 8'h99);
    chk("b_wrap_sel", {2'b0, sel_b}, 8'h3E);
    chk("b_wrap_fs", {7'b0, fs_b}, 8'h01);
    chk("b_wrap_seg", so_b, 8'h00);
    to_edge(31);
    chk("d5_sel", {2'b0, sel_a}, 8'h1F);
    chk("d5_seg", so_a, 8'h92);
    to_edge(36);
    chk("d5_blank_sel", {2'b0, sel_a}, 8'h3F);
    chk("d5_blank_fs", {7'b0, fs_a}, 8'h00);
    to_edge(37);
    chk("f2_sel", {2'b0, sel_a}, 8'h3E);
    chk("f2_fs", {7'b0, fs_a}, 8'h01);
    chk("f2_seg_new", so_a, 8'h00);
    to_edge(49);
    chk("b_f3_fs", {7'b0, fs_b}, 8'h01);
    to_edge(53);
    chk("f2_d2_blank", {2'b0, sel_a}, 8'h3F);
    en_a = 1'b0;
    to_edge(54);
    chk("idle_sel", {2'b0, sel_a}, 8'h3F);
    chk("idle_seg", so_a, 8'hFF);
    chk("idle_fs", {7'b0, fs_a}, 8'h00);
    to_edge(56);
    chk("idle_sel_2", {2'b0, sel_a}, 8'h3F);
    en_a = 1'b1;
    s0 = 7'h79;
    to_edge(57);
    chk("restart_sel", {2'b0, sel_a}, 8'h3E);
    chk("restart_fs", {7'b0, fs_a}, 8'h01);
    chk("restart_seg", so_a, 8'h79);
    to_edge(58);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_sel", {2'b0, sel_a}, 8'h3F);
    chk("async_seg", so_a, 8'hFF);
    chk("async_fs", {7'b0, fs_a}, 8'h00);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_sel", {2'b0, sel_a}, 8'h3E);
    chk("post_rst_fs", {7'b0, fs_a}, 8'h01);
    chk("post_rst_seg", so_a, 8'h79);
    repeat (7) tick();
    chk("post_rst_d1", {2'b0, sel_a}, 8'h3D);
    repeat (40) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
